// File: rtl/matrix_col_readout.sv
// matrix_col_readout: freezes the pixel matrix on any enabled token, drains columns lowest-index first
// and streams {col, pixel word} to the serialiser over valid/ready.
module matrix_col_readout #(
  parameter int N_COL      = 56,
  parameter int DATA_W     = 21,
  parameter int COL_W      = 6,
  parameter int FRZ_SETTLE = 2,
  parameter int READ_PULSE = 2,
  parameter int TOK_SETTLE = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [N_COL-1:0]         col_en,
  input  logic [N_COL-1:0]         ntok,
  input  logic [N_COL*DATA_W-1:0]  data,
  output logic [N_COL-1:0]         freeze,
  output logic [N_COL-1:0]         read,
  output logic [COL_W+DATA_W-1:0]  out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic [15:0]              hit_cnt
);
  typedef enum logic [2:0] {IDLE, FRZ, SCAN, RD, SETL, PUSH, UNFRZ} state_t;
  state_t state, state_n;
  logic [7:0] cnt;
  logic [COL_W-1:0] col, low;
  logic [DATA_W-1:0] word;
  logic [N_COL-1:0] tok;
  logic any_tok;
  assign tok = ~ntok & col_en;
  assign any_tok = |tok;
  always_comb begin
    low = '0;
    for (int i = N_COL - 1; i >= 0; i--)
      if (tok[i]) low = COL_W'(i);
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = (en && any_tok) ? FRZ : IDLE;
      FRZ:   state_n = (cnt == 8'(FRZ_SETTLE - 1)) ? SCAN : FRZ;
      SCAN:  state_n = (en && any_tok) ? RD : UNFRZ;
      RD:    state_n = (cnt == 8'(READ_PULSE - 1)) ? SETL : RD;
      SETL:  state_n = (cnt == 8'(TOK_SETTLE - 1)) ? PUSH : SETL;
      PUSH:  state_n = out_ready ? SCAN : PUSH;
      UNFRZ: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      col       <= '0;
      word      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      hit_cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= (state_n != state) ? 8'd0 : cnt + 8'd1;
      if (state == IDLE && state_n == FRZ) hit_cnt <= '0;
      if (state == SCAN && state_n == RD) col <= low;
      if (state == RD && state_n == SETL) word <= data[col*DATA_W +: DATA_W];
      if (state == SETL && state_n == PUSH) begin
        out_data  <= {col, word};
        out_valid <= 1'b1;
      end
      if (state == PUSH && out_ready) begin
        out_valid <= 1'b0;
        hit_cnt   <= (&hit_cnt) ? hit_cnt : hit_cnt + 16'd1;
      end
    end
  end
  // Strobes decode straight from state so an async reset drops them at once.
  assign freeze = {N_COL{state != IDLE && state != UNFRZ}};
  assign read   = (state == RD) ? (N_COL'(1) << col) : '0;
  assign busy   = state != IDLE;
endmodule

// File: tb/tb_matrix_col_readout.sv
// tb_matrix_col_readout: randomized bench with a behavioural pixel-column model and an ordered-drain reference.
module tb_matrix_col_readout;
  localparam int N = 56;
  localparam int DW = 21;
  logic clk = 0, rst_n = 0, en = 0, out_ready = 0;
  logic [N-1:0] col_en = '1, ntok = '1;
  logic [N*DW-1:0] data = '0;
  logic [N-1:0] freeze, read;
  logic [26:0] out_data;
  logic out_valid, busy;
  logic [15:0] hit_cnt;
  logic [DW-1:0] colq [N][$];
  logic [26:0] got[$], exp_q[$];
  logic [N-1:0] prev_read;
  logic prev_frz;
  int errs = 0, checks = 0, frz_rises = 0, viol = 0;

  matrix_col_readout dut (
    .clk(clk), .rst_n(rst_n), .en(en), .col_en(col_en), .ntok(ntok), .data(data),
    .freeze(freeze), .read(read), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .hit_cnt(hit_cnt)
  );

  always #5 clk = ~clk;

  // Column model: a column pops its oldest hit when a Read pulse ends outside reset.
  initial begin
    prev_read = '0;
    forever begin
      @(negedge clk);
      for (int c = 0; c < N; c++)
        if (rst_n && prev_read[c] && !read[c] && colq[c].size() > 0) void'(colq[c].pop_front());
      prev_read = read;
      for (int c = 0; c < N; c++) begin
        ntok[c] = (colq[c].size() == 0);
        data[c*DW +: DW] = (colq[c].size() > 0) ? colq[c][0] : '0;
      end
    end
  end

  initial begin
    prev_frz = 0;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) got.push_back(out_data);
      if (freeze[0] && !prev_frz) frz_rises++;
      prev_frz = freeze[0];
      if (read != '0 && (!$onehot(read) || freeze != '1)) viol++;
      if (freeze != '0 && freeze != '1) viol++;
    end
  end

  // Reference: every enabled column drained in ascending index order, hits in arrival order.
  task automatic build_exp();
    exp_q.delete();
    for (int c = 0; c < N; c++)
      if (col_en[c])
        for (int j = 0; j < colq[c].size(); j++) exp_q.push_back({6'(c), colq[c][j]});
  endtask

  task automatic wait_busy(input logic lvl, input int max, input bit rnd, output bit to);
    int n = 0;
    while (busy !== lvl && n < max) begin
      @(posedge clk); #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    to = (busy !== lvl);
  endtask

  task automatic run_frame(input bit rnd, output bit to);
    bit t1, t2;
    wait_busy(1'b1, 200, rnd, t1);
    wait_busy(1'b0, 2000, rnd, t2);
    out_ready = 1;
    to = t1 | t2;
  endtask

  task automatic start_scn();
    @(posedge clk); #1;
    got.delete();
    frz_rises = 0;
    out_ready = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; en = 1; col_en = '1; out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (freeze !== '0) begin errs++; $display("FAIL reset_freeze got %h want 0", freeze); end
    checks++; if (read !== '0) begin errs++; $display("FAIL reset_read got %h want 0", read); end
    checks++; if (out_valid !== 0) begin errs++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_data !== '0) begin errs++; $display("FAIL reset_data got %h want 0", out_data); end
    checks++; if (busy !== 0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (hit_cnt !== 0) begin errs++; $display("FAIL reset_hitcnt got %0d want 0", hit_cnt); end
    rst_n = 1;
  endtask

  task automatic test_single();
    int n = 0, k = 0, v0 = viol;
    bit to;
    logic [N-1:0] er = '0;
    er[5] = 1;
    start_scn();
    colq[5].push_back(21'h1ABCD);
    build_exp();
    @(negedge clk); #1;
    while (read == '0 && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (n != 4) begin errs++; $display("FAIL single_latency got %0d want 4", n); end
    checks++; if (read !== er) begin errs++; $display("FAIL single_read got %h want %h", read, er); end
    checks++; if (freeze !== '1) begin errs++; $display("FAIL single_freeze got %h want all ones", freeze); end
    while (read[5] && k < 10) begin @(posedge clk); #1; k++; end
    checks++; if (k != 2) begin errs++; $display("FAIL single_pulse got %0d want 2", k); end
    wait_busy(1'b0, 200, 0, to);
    checks++; if (to) begin errs++; $display("FAIL single_timeout got busy %b want 0", busy); end
    checks++; if (got.size() != 1 || got[0] !== 27'({6'd5, 21'h1ABCD})) begin
      errs++; $display("FAIL single_word got %p want %h", got, 27'({6'd5, 21'h1ABCD}));
    end
    checks++; if (hit_cnt !== 16'd1) begin errs++; $display("FAIL single_hitcnt got %0d want 1", hit_cnt); end
    checks++; if (freeze !== '0) begin errs++; $display("FAIL single_unfreeze got %h want 0", freeze); end
    checks++; if (viol != v0 || frz_rises != 1) begin errs++; $display("FAIL single_invariant got viol=%0d rises=%0d want %0d/1", viol, frz_rises, v0); end
  endtask

  task automatic test_order();
    bit to;
    start_scn();
    colq[55].push_back(21'($urandom));
    colq[0].push_back(21'($urandom));
    colq[17].push_back(21'($urandom));
    build_exp();
    run_frame(0, to);
    checks++; if (to) begin errs++; $display("FAIL order_timeout got busy %b want 0", busy); end
    checks++; if (got.size() != exp_q.size()) begin errs++; $display("FAIL order_count got %0d want %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errs++; $display("FAIL order_word%0d got %h want %h", i, got[i], exp_q[i]); end
    end
    checks++; if (hit_cnt !== 16'd3 || frz_rises != 1) begin errs++; $display("FAIL order_frame got hit=%0d rises=%0d want 3/1", hit_cnt, frz_rises); end
  endtask

  task automatic test_multi_hit();
    bit to;
    start_scn();
    repeat (4) colq[3].push_back(21'($urandom));
    build_exp();
    run_frame(0, to);
    checks++; if (to) begin errs++; $display("FAIL multi_timeout got busy %b want 0", busy); end
    checks++; if (got.size() != 4) begin errs++; $display("FAIL multi_count got %0d want 4", got.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errs++; $display("FAIL multi_word%0d got %h want %h", i, got[i], exp_q[i]); end
    end
    checks++; if (hit_cnt !== 16'd4 || frz_rises != 1) begin errs++; $display("FAIL multi_frame got hit=%0d rises=%0d want 4/1", hit_cnt, frz_rises); end
  endtask

  task automatic test_stall();
    int n = 0;
    bit to;
    logic [26:0] snap;
    start_scn();
    out_ready = 0;
    colq[7].push_back(21'($urandom));
    colq[7].push_back(21'($urandom));
    build_exp();
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    snap = out_data;
    checks++; if (snap !== exp_q[0]) begin errs++; $display("FAIL stall_first got %h want %h", snap, exp_q[0]); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1 || out_data !== snap || read !== '0) begin
        errs++; $display("FAIL stall_hold%0d got v=%b d=%h rd=%h want 1/%h/0", i, out_valid, out_data, read, snap);
      end
    end
    out_ready = 1;
    wait_busy(1'b0, 200, 0, to);
    checks++; if (to) begin errs++; $display("FAIL stall_timeout got busy %b want 0", busy); end
    checks++; if (got.size() != 2) begin errs++; $display("FAIL stall_count got %0d want 2", got.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errs++; $display("FAIL stall_word%0d got %h want %h", i, got[i], exp_q[i]); end
    end
    checks++; if (hit_cnt !== 16'd2) begin errs++; $display("FAIL stall_hitcnt got %0d want 2", hit_cnt); end
  endtask

  task automatic test_mask_en();
    int n = 0;
    bit to, idle_ok = 1;
    logic [20:0] w = 21'($urandom);
    start_scn();
    col_en[9] = 0;
    colq[9].push_back(21'($urandom));
    repeat (20) begin @(posedge clk); #1; if (busy !== 0) idle_ok = 0; end
    checks++; if (!idle_ok) begin errs++; $display("FAIL mask_busy got 1 want 0"); end
    colq[2].push_back(w);
    colq[20].push_back(21'($urandom));
    while (!read[2] && n < 50) begin @(posedge clk); #1; n++; end
    en = 0;
    wait_busy(1'b0, 200, 0, to);
    checks++; if (to) begin errs++; $display("FAIL en_timeout got busy %b want 0", busy); end
    checks++; if (got.size() != 1 || got[0] !== {6'd2, w}) begin errs++; $display("FAIL en_word got %p want %h", got, {6'd2, w}); end
    checks++; if (freeze !== '0 || hit_cnt !== 16'd1) begin errs++; $display("FAIL en_release got frz=%h hit=%0d want 0/1", freeze, hit_cnt); end
    idle_ok = 1;
    repeat (10) begin @(posedge clk); #1; if (busy !== 0) idle_ok = 0; end
    checks++; if (!idle_ok) begin errs++; $display("FAIL en_idle got busy want idle"); end
    colq[9].delete(); colq[20].delete();
    col_en = '1; en = 1;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    bit to;
    logic [20:0] w = 21'($urandom);
    start_scn();
    colq[4].push_back(w);
    while (!read[4] && n < 50) begin @(posedge clk); #1; n++; end
    #1 rst_n = 0;
    #1;
    checks++;
    if (freeze !== '0 || read !== '0 || out_valid !== 0 || out_data !== '0 || busy !== 0 || hit_cnt !== 0) begin
      errs++; $display("FAIL rstmid_outputs got frz=%h rd=%h v=%b d=%h b=%b h=%0d want all 0", freeze, read, out_valid, out_data, busy, hit_cnt);
    end
    repeat (2) @(negedge clk);
    #1 rst_n = 1;
    got.delete();
    run_frame(0, to);
    checks++; if (to) begin errs++; $display("FAIL rstmid_timeout got busy %b want 0", busy); end
    checks++; if (got.size() != 1 || got[0] !== {6'd4, w}) begin errs++; $display("FAIL rstmid_word got %p want %h", got, {6'd4, w}); end
    checks++; if (hit_cnt !== 16'd1) begin errs++; $display("FAIL rstmid_hitcnt got %0d want 1", hit_cnt); end
  endtask

  task automatic test_random();
    bit to;
    for (int it = 0; it < 5; it++) begin
      start_scn();
      repeat ($urandom_range(1, 6)) begin
        int c = $urandom_range(0, N - 1);
        repeat ($urandom_range(1, 3)) colq[c].push_back(21'($urandom));
      end
      build_exp();
      run_frame(1, to);
      checks++; if (to) begin errs++; $display("FAIL rand%0d_timeout got busy %b want 0", it, busy); end
      checks++; if (got.size() != exp_q.size()) begin errs++; $display("FAIL rand%0d_count got %0d want %0d", it, got.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
        checks++; if (got[i] !== exp_q[i]) begin errs++; $display("FAIL rand%0d_word%0d got %h want %h", it, i, got[i], exp_q[i]); end
      end
      checks++; if (hit_cnt !== 16'(exp_q.size()) || frz_rises != 1) begin
        errs++; $display("FAIL rand%0d_frame got hit=%0d rises=%0d want %0d/1", it, hit_cnt, frz_rises, exp_q.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_order();
    test_multi_hit();
    test_stall();
    test_mask_en();
    test_reset_mid();
    test_random();
    checks++; if (viol != 0) begin errs++; $display("FAIL read_invariant got %0d violations want 0", viol); end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
